// File: rtl/uart_pkg.sv
// Shared encodings for the UART memory-access engine: FSM states, command codes
// and byte width.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [7:0] CMD_DO_MEM_WRITE = 8'd11;
  localparam logic [7:0] CMD_DO_MEM_READ  = 8'd12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WR_RX  = 3'd1,
    ST_WR_MEM = 3'd2,
    ST_RD_MEM = 3'd3,
    ST_RD_TXS = 3'd4,
    ST_RD_TXW = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/uart_mem_access_engine.sv
// Executes UART memory write/read bursts: one byte per count on a req/gnt port,
// write bytes sourced from uart_rx, read bytes forwarded to uart_tx.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | waiting for start_wr / start_rd
// ST_WR_RX  | waiting for the next rx byte
// ST_WR_MEM | writing the captured byte at addr_q
// ST_RD_MEM | reading the byte at addr_q
// ST_RD_TXS | requesting the transmitter until it reports busy
// ST_RD_TXW | waiting for the transmitter to finish the byte
// ST_DONE   | one-cycle completion pulse
module uart_mem_access_engine
  import uart_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int COUNT_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_wr,
  input  logic              start_rd,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [COUNT_W-1:0] cfg_count,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [ADDR_W-1:0] next_addr,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_busy,
  output logic              tx_enable,
  output logic [7:0]        tx_data,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_rdata
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [COUNT_W-1:0]  remaining_q;
  logic [DATA_W-1:0]   data_q;
  logic                overrun_q;

  logic accept_start;
  logic step;
  logic load_rx;
  logic load_rd;
  logic last;

  always_comb begin
    state_d      = state_q;
    accept_start = 1'b0;
    step         = 1'b0;
    load_rx      = 1'b0;
    load_rd      = 1'b0;
    busy         = (state_q != ST_IDLE);
    done         = 1'b0;
    mem_req      = 1'b0;
    mem_wen      = 1'b0;
    tx_enable    = 1'b0;
    last         = (remaining_q == COUNT_W'(1));

    case (state_q)
      ST_IDLE: begin
        if (start_wr || start_rd) begin
          accept_start = 1'b1;
          if (cfg_count == '0)
            state_d = ST_DONE;
          else if (start_wr)
            state_d = ST_WR_RX;
          else
            state_d = ST_RD_MEM;
        end
      end
      ST_WR_RX: begin
        if (rx_valid) begin
          load_rx = 1'b1;
          state_d = ST_WR_MEM;
        end
      end
      ST_WR_MEM: begin
        mem_req = 1'b1;
        mem_wen = 1'b1;
        if (mem_gnt) begin
          step    = 1'b1;
          state_d = last ? ST_DONE : ST_WR_RX;
        end
      end
      ST_RD_MEM: begin
        mem_req = 1'b1;
        if (mem_gnt) begin
          load_rd = 1'b1;
          state_d = ST_RD_TXS;
        end
      end
      ST_RD_TXS: begin
        tx_enable = 1'b1;
        if (tx_busy)
          state_d = ST_RD_TXW;
      end
      ST_RD_TXW: begin
        if (!tx_busy) begin
          step    = 1'b1;
          state_d = last ? ST_DONE : ST_RD_MEM;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort withdraws requests combinationally so the bus sees no further access.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      step      = 1'b0;
      load_rx   = 1'b0;
      load_rd   = 1'b0;
      mem_req   = 1'b0;
      mem_wen   = 1'b0;
      tx_enable = 1'b0;
      done      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept_start) begin
        addr_q      <= cfg_addr;
        remaining_q <= cfg_count;
      end else if (step) begin
        addr_q      <= addr_q + ADDR_W'(1);
        remaining_q <= remaining_q - COUNT_W'(1);
      end

      if (load_rx)
        data_q <= rx_data;
      else if (load_rd)
        data_q <= mem_rdata;

      // A byte arriving while the write is still pending is dropped, not queued.
      if (accept_start)
        overrun_q <= 1'b0;
      else if ((state_q == ST_WR_MEM) && rx_valid)
        overrun_q <= 1'b1;
    end
  end

  assign overrun   = overrun_q;
  assign next_addr = addr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;
  assign tx_data   = data_q;

endmodule

// File: tb/tb_uart_mem_access_engine.sv
// Self-checking bench for uart_mem_access_engine: directed vector table, hand-written
// corner sequences and randomized bursts against a burst-level reference model.
module tb_uart_mem_access_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_wr, start_rd, abort;
  logic [31:0] cfg_addr;
  logic [6:0]  cfg_count;
  logic        busy, done, overrun;
  logic [31:0] next_addr;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_busy, tx_enable;
  logic [7:0]  tx_data;
  logic        mem_req, mem_wen, mem_gnt;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  uart_mem_access_engine #(.ADDR_W(32), .COUNT_W(7)) dut (
    .clk(clk), .reset(reset), .start_wr(start_wr), .start_rd(start_rd),
    .cfg_addr(cfg_addr), .cfg_count(cfg_count), .abort(abort),
    .busy(busy), .done(done), .overrun(overrun), .next_addr(next_addr),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_busy(tx_busy),
    .tx_enable(tx_enable), .tx_data(tx_data), .mem_req(mem_req),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave behaviour knobs, written only by the main sequence.
  int gnt_delay = 0;
  bit gnt_hold  = 0;
  int tx_len    = 2;
  bit tx_hold   = 0;

  logic [7:0]  mem_model [logic [31:0]];
  logic [31:0] acc_addr[$];
  bit          acc_wen[$];
  logic [7:0]  acc_data[$];
  logic [7:0]  tx_log[$];
  int done_cnt = 0, req_cnt = 0, txen_cnt = 0, viol = 0;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [6:0]  count;
    logic [7:0]  b0;
    int          gdly;
    logic [31:0] exp_next;
  } vec_t;
  vec_t vecs[6];

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] exp_byte(input bit wr, input logic [31:0] a,
                                          input logic [7:0] b0, input int i);
    if (wr) return 8'(b0 + 8'(i) * 8'h11);
    return rd_byte(a + 32'(i));
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory slave: grants gnt_delay cycles after req, for one cycle.
  initial begin
    int wcnt;
    wcnt = 0; mem_gnt = 1'b0; mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (reset || mem_gnt) begin
        mem_gnt = 1'b0; wcnt = 0;
      end else if (mem_req && !gnt_hold) begin
        if (wcnt >= gnt_delay) begin
          mem_gnt   = 1'b1;
          mem_rdata = mem_wen ? 8'h00 : rd_byte(mem_addr);
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  // Transmitter: accepts on tx_enable, stays busy for tx_len cycles.
  initial begin
    int left;
    left = 0; tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_enable && tx_busy) viol++;
      if (reset) begin
        tx_busy = 1'b0; left = 0;
      end else if (tx_busy) begin
        if (left <= 1) tx_busy = 1'b0; else left--;
      end else if (tx_enable && !tx_hold) begin
        tx_busy = 1'b1; left = tx_len; tx_log.push_back(tx_data);
      end
    end
  end

  // Bus observer.
  initial begin
    forever begin
      @(posedge clk);
      if (mem_req && mem_gnt) begin
        acc_addr.push_back(mem_addr);
        acc_wen.push_back(mem_wen);
        acc_data.push_back(mem_wen ? mem_wdata : mem_rdata);
      end
      if (done) done_cnt++;
      if (mem_req) req_cnt++;
      if (tx_enable) txen_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_acc(input int target);
    int k = 0;
    while (acc_addr.size() < target && k < 60) begin @(negedge clk); k++; end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 400) begin @(negedge clk); k++; end
  endtask

  task automatic run_burst(input bit wr, input logic [31:0] a, input logic [6:0] n,
                           input logic [7:0] b0, input logic [31:0] exp_next,
                           input string tag);
    int acc0, tx0, d0, r0, t0;
    acc0 = acc_addr.size(); tx0 = tx_log.size();
    d0 = done_cnt; r0 = req_cnt; t0 = txen_cnt;
    @(negedge clk);
    cfg_addr = a; cfg_count = n; start_wr = wr; start_rd = !wr;
    @(negedge clk);
    start_wr = 1'b0; start_rd = 1'b0;
    if (wr) begin
      for (int i = 0; i < int'(n); i++) begin
        rx_valid = 1'b1; rx_data = exp_byte(1'b1, a, b0, i);
        @(negedge clk);
        rx_valid = 1'b0;
        wait_acc(acc0 + i + 1);
      end
    end
    wait_idle();
    check({tag, ".busy_end"}, 32'(busy), 32'd0);
    check({tag, ".done_cnt"}, 32'(done_cnt - d0), 32'd1);
    check({tag, ".next_addr"}, next_addr, exp_next);
    check({tag, ".n_access"}, 32'(acc_addr.size() - acc0), 32'(n));
    for (int i = 0; i < int'(n) && acc0 + i < acc_addr.size(); i++) begin
      check($sformatf("%s.addr%0d", tag, i), acc_addr[acc0+i], a + 32'(i));
      check($sformatf("%s.wen%0d", tag, i), 32'(acc_wen[acc0+i]), 32'(wr));
      check($sformatf("%s.data%0d", tag, i), 32'(acc_data[acc0+i]), 32'(exp_byte(wr, a, b0, i)));
    end
    check({tag, ".n_tx"}, 32'(tx_log.size() - tx0), wr ? 32'd0 : 32'(n));
    if (!wr)
      for (int i = 0; i < int'(n) && tx0 + i < tx_log.size(); i++)
        check($sformatf("%s.tx%0d", tag, i), 32'(tx_log[tx0+i]), 32'(rd_byte(a + 32'(i))));
    if (n == 7'd0) begin
      check({tag, ".no_req"}, 32'(req_cnt - r0), 32'd0);
      check({tag, ".no_txen"}, 32'(txen_cnt - t0), 32'd0);
    end
  endtask

  initial begin
    int acc0, d0;
    int k;
    logic [31:0] ra;
    logic [6:0]  rn;
    bit          rw;

    vecs[0] = '{1'b1, 32'h0000_1000, 7'd3, 8'hA1, 0, 32'h0000_1003};
    vecs[1] = '{1'b1, 32'h0000_0000, 7'd0, 8'h00, 0, 32'h0000_0000};
    vecs[2] = '{1'b0, 32'h0000_0055, 7'd0, 8'h00, 0, 32'h0000_0055};
    vecs[3] = '{1'b1, 32'hFFFF_FFFF, 7'd2, 8'h10, 1, 32'h0000_0001};
    vecs[4] = '{1'b0, 32'h0000_0020, 7'd2, 8'h00, 2, 32'h0000_0022};
    vecs[5] = '{1'b0, 32'hFFFF_FFFE, 7'd3, 8'h00, 0, 32'h0000_0001};
    mem_model[32'h20] = 8'h5A;
    mem_model[32'h21] = 8'h7E;

    reset = 1'b1; start_wr = 1'b0; start_rd = 1'b0; abort = 1'b0;
    cfg_addr = 32'h0; cfg_count = 7'd0; rx_valid = 1'b0; rx_data = 8'h0;
    repeat (3) @(negedge clk);
    check("rst.busy", 32'(busy), 0);
    check("rst.done", 32'(done), 0);
    check("rst.overrun", 32'(overrun), 0);
    check("rst.next_addr", next_addr, 0);
    check("rst.mem_req", 32'(mem_req), 0);
    check("rst.tx_enable", 32'(tx_enable), 0);
    check("rst.tx_data", 32'(tx_data), 0);
    reset = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      gnt_delay = vecs[v].gdly;
      run_burst(vecs[v].wr, vecs[v].addr, vecs[v].count, vecs[v].b0,
                vecs[v].exp_next, $sformatf("vec%0d", v));
    end
    gnt_delay = 0;

    // Zero-count start: done exactly one cycle after the start.
    @(negedge clk);
    cfg_addr = 32'h77; cfg_count = 7'd0; start_rd = 1'b1;
    d0 = req_cnt; k = txen_cnt;
    @(negedge clk);
    start_rd = 1'b0;
    check("cnt0.done_hi", 32'(done), 1);
    check("cnt0.busy_hi", 32'(busy), 1);
    @(negedge clk);
    check("cnt0.done_lo", 32'(done), 0);
    check("cnt0.busy_lo", 32'(busy), 0);
    check("cnt0.no_req", 32'(req_cnt - d0), 0);
    check("cnt0.no_txen", 32'(txen_cnt - k), 0);
    check("cnt0.next_addr", next_addr, 32'h77);

    // Both starts: write wins; a start while busy is ignored.
    @(negedge clk);
    cfg_addr = 32'h600; cfg_count = 7'd1; start_wr = 1'b1; start_rd = 1'b1;
    acc0 = acc_addr.size(); d0 = done_cnt;
    @(negedge clk);
    start_wr = 1'b0; start_rd = 1'b0;
    repeat (3) @(negedge clk);
    check("both.no_req", 32'(mem_req), 0);
    check("both.busy", 32'(busy), 1);
    cfg_addr = 32'h900; cfg_count = 7'd5; start_rd = 1'b1;
    @(negedge clk);
    start_rd = 1'b0;
    rx_valid = 1'b1; rx_data = 8'hEE;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle();
    check("both.n_access", 32'(acc_addr.size() - acc0), 1);
    if (acc_addr.size() > acc0) begin
      check("both.addr", acc_addr[acc0], 32'h600);
      check("both.wen", 32'(acc_wen[acc0]), 1);
      check("both.data", 32'(acc_data[acc0]), 32'hEE);
    end
    check("both.next_addr", next_addr, 32'h601);
    check("both.done_cnt", 32'(done_cnt - d0), 1);

    // Overrun: rx byte while the write is held off.
    gnt_hold = 1'b1;
    @(negedge clk);
    cfg_addr = 32'h300; cfg_count = 7'd2; start_wr = 1'b1;
    @(negedge clk);
    start_wr = 1'b0;
    acc0 = acc_addr.size();
    rx_valid = 1'b1; rx_data = 8'h11;
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h99;
    check("ovr.req", 32'(mem_req), 1);
    @(negedge clk);
    rx_valid = 1'b0;
    check("ovr.set", 32'(overrun), 1);
    gnt_hold = 1'b0;
    wait_acc(acc0 + 1);
    @(negedge clk);
    if (acc_addr.size() > acc0) begin
      check("ovr.addr0", acc_addr[acc0], 32'h300);
      check("ovr.data0", 32'(acc_data[acc0]), 32'h11);
    end
    check("ovr.sticky1", 32'(overrun), 1);
    check("ovr.next_mid", next_addr, 32'h301);
    check("ovr.busy_mid", 32'(busy), 1);
    rx_valid = 1'b1; rx_data = 8'h22;
    @(negedge clk);
    rx_valid = 1'b0;
    wait_idle();
    check("ovr.n_access", 32'(acc_addr.size() - acc0), 2);
    if (acc_addr.size() > acc0 + 1)
      check("ovr.data1", 32'(acc_data[acc0+1]), 32'h22);
    check("ovr.next_end", next_addr, 32'h302);
    check("ovr.sticky2", 32'(overrun), 1);
    cfg_count = 7'd0; start_wr = 1'b1;
    @(negedge clk);
    start_wr = 1'b0;
    check("ovr.cleared", 32'(overrun), 0);
    @(negedge clk);
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("ovr.idle_rx", 32'(overrun), 0);

    // Abort while requesting the transmitter; rx noise in read states ignored.
    tx_hold = 1'b1;
    cfg_addr = 32'h40; cfg_count = 7'd3; start_rd = 1'b1;
    @(negedge clk);
    start_rd = 1'b0;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    k = 0;
    while (!tx_enable && k < 50) begin @(negedge clk); k++; end
    check("abort.txen_before", 32'(tx_enable), 1);
    d0 = done_cnt;
    abort = 1'b1;
    #1;
    check("abort.txen_drop", 32'(tx_enable), 0);
    check("abort.req_drop", 32'(mem_req), 0);
    @(negedge clk);
    abort = 1'b0;
    check("abort.busy", 32'(busy), 0);
    check("abort.next_addr", next_addr, 32'h40);
    repeat (3) @(negedge clk);
    check("abort.no_done", 32'(done_cnt - d0), 0);
    check("abort.no_req", 32'(mem_req), 0);
    check("abort.no_ovr", 32'(overrun), 0);
    tx_hold = 1'b0;

    // Asynchronous reset while a write is pending on the bus.
    gnt_hold = 1'b1;
    @(negedge clk);
    cfg_addr = 32'h500; cfg_count = 7'd2; start_wr = 1'b1;
    @(negedge clk);
    start_wr = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h42;
    @(negedge clk);
    rx_valid = 1'b0;
    check("arst.req_before", 32'(mem_req), 1);
    check("arst.wdata_before", 32'(mem_wdata), 32'h42);
    acc0 = acc_addr.size(); d0 = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("arst.req", 32'(mem_req), 0);
    check("arst.busy", 32'(busy), 0);
    check("arst.next_addr", next_addr, 0);
    check("arst.wdata", 32'(mem_wdata), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    gnt_hold = 1'b0;
    repeat (5) @(negedge clk);
    check("arst.no_access", 32'(acc_addr.size() - acc0), 0);
    check("arst.no_done", 32'(done_cnt - d0), 0);
    check("arst.idle", 32'(busy), 0);

    // Randomized bursts against the burst-level model.
    for (int r = 0; r < 20; r++) begin
      rw = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3)) : 32'($urandom);
      rn = 7'($urandom_range(0, 6));
      gnt_delay = int'($urandom_range(0, 3));
      tx_len = int'($urandom_range(1, 3));
      run_burst(rw, ra, rn, 8'($urandom), ra + 32'(rn), $sformatf("rnd%0d", r));
    end

    check("tx_en_while_busy", 32'(viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
